entropy_decode_ac_run_coefficients_bits: RTL and testbench

Bit-serial decoder for ProRes AC run codewords; inverse of the encoder-side AC run coding. It consumes one bitstream bit per cycle, selects the adaptive Rice/exp-Golomb codebook from the previous decoded run, and emits each decoded run value under a valid/ready handshake. It sits in the VLC decode path beside the AC level decoder, and the slice-level bit arbiter feeds it only the bits of run codewords.

---
 rtl/prores_vlc_pkg.sv | 35 +++
 rtl/entropy_decode_ac_run_coefficients_bits_if.sv | 31 +++
 rtl/vlc_bit_prefix_counter.sv | 44 ++++
 rtl/entropy_decode_ac_run_coefficients_bits.sv | 204 ++++++++++++++++++++
 tb/tb_entropy_decode_ac_run_coefficients_bits.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/prores_vlc_pkg.sv
// rtl/prores_vlc_pkg.sv - shared ProRes VLC run-context constants, FSM state type and codebook selection
package prores_vlc_pkg;

    // Run context value after reset / block start, and its saturation ceiling.
    localparam logic [3:0] RUN_CTX_INIT = 4'd4;
    localparam logic [3:0] RUN_CTX_MAX  = 4'd15;

    typedef enum logic [1:0] {
        ST_PREFIX,
        ST_SUFFIX,
        ST_EMIT,
        ST_ERROR
    } run_dec_state_e;

    // lastq_plus1 = lastQ + 1, so lastQ = -1 is encoded as 0 and the Rice
    // branch is taken when the zero count is strictly below lastq_plus1.
    typedef struct packed {
        logic [1:0] lastq_plus1;
        logic [1:0] kr;
        logic [1:0] ke;
    } run_codebook_t;

    // Codebook parameters selected by the previous decoded run (saturated to 4 bits).
    function automatic run_codebook_t run_codebook(input logic [3:0] prev);
        run_codebook_t cb;
        if (prev <= 4'd1)       cb = '{lastq_plus1: 2'd3, kr: 2'd0, ke: 2'd1};
        else if (prev <= 4'd3)  cb = '{lastq_plus1: 2'd2, kr: 2'd0, ke: 2'd1};
        else if (prev == 4'd4)  cb = '{lastq_plus1: 2'd0, kr: 2'd0, ke: 2'd0};
        else if (prev <= 4'd8)  cb = '{lastq_plus1: 2'd2, kr: 2'd1, ke: 2'd2};
        else if (prev <= 4'd14) cb = '{lastq_plus1: 2'd0, kr: 2'd0, ke: 2'd1};
        else                    cb = '{lastq_plus1: 2'd0, kr: 2'd0, ke: 2'd2};
        return cb;
    endfunction

endpackage

// File: rtl/entropy_decode_ac_run_coefficients_bits_if.sv
// rtl/entropy_decode_ac_run_coefficients_bits_if.sv - bit-in / run-out handshake bundle for the AC run decoder
//
// Signals:
//   block_start          new AC run sequence (context reload, abort partial codeword)
//   in_bit/in_valid      bitstream input, MSB first; accepted when in_valid & in_ready
//   in_ready             decoder can take a bit this cycle
//   out_run/out_valid    decoded run, accepted when out_valid & out_ready
//   out_error            sticky malformed/oversize codeword flag
// master = bit source / run sink side, slave = decoder side.
interface entropy_decode_ac_run_coefficients_bits_if #(
    parameter int RUN_W = 16
);
    logic             block_start;
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic [RUN_W-1:0] out_run;
    logic             out_valid;
    logic             out_ready;
    logic             out_error;

    modport master (
        output block_start, in_bit, in_valid, out_ready,
        input  in_ready, out_run, out_valid, out_error
    );

    modport slave (
        input  block_start, in_bit, in_valid, out_ready,
        output in_ready, out_run, out_valid, out_error
    );
endinterface

// File: rtl/vlc_bit_prefix_counter.sv
// rtl/vlc_bit_prefix_counter.sv - leading-zero counter with limit detection for VLC prefix decoding
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear_i      return the count to zero (wins over inc_i)
//   inc_i        one more leading zero accepted
//   count_o      zeros counted so far
//   limit_o      inc_i would push the count past MAX_COUNT (count is then held)
module vlc_bit_prefix_counter #(
    parameter int MAX_COUNT = 24,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             limit_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign limit_o = inc_i && (count_q == CNT_W'(MAX_COUNT));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !limit_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/entropy_decode_ac_run_coefficients_bits.sv
// rtl/entropy_decode_ac_run_coefficients_bits.sv - bit-serial ProRes AC run codeword decoder with adaptive codebook
//
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    slave side of the handshake bundle (bits in, runs out, error flag)
// Parameters:
//   RUN_W       width of the decoded run
//   MAX_PREFIX  longest leading-zero prefix accepted before flagging an error
module entropy_decode_ac_run_coefficients_bits
    import prores_vlc_pkg::*;
#(
    parameter int RUN_W      = 16,
    parameter int MAX_PREFIX = 24
) (
    input  logic clk,
    input  logic reset,
    entropy_decode_ac_run_coefficients_bits_if.slave bus
);

    localparam int ACC_W  = MAX_PREFIX + 3;
    localparam int ZCNT_W = $clog2(MAX_PREFIX + 1);
    // Longest suffix is MAX_PREFIX zeros past the escape point plus ke=2.
    localparam int LEN_W  = $clog2(MAX_PREFIX + 3);

    run_dec_state_e   state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] len_q, len_d;
    run_codebook_t    cb_q, cb_d;
    logic             rice_q, rice_d;
    logic [RUN_W-1:0] run_q, run_d;

    logic             accept;
    logic [ZCNT_W-1:0] zcnt;
    logic             zcnt_limit;
    logic             zcnt_inc;
    logic             zcnt_clear;

    run_codebook_t    cb_new;
    logic             rice_new;
    logic [ACC_W-1:0] acc_init;
    logic [LEN_W-1:0] len_new;
    logic [ACC_W-1:0] acc_shift;
    logic [ACC_W-1:0] fin_acc;
    logic             fin_rice;
    run_codebook_t    fin_cb;
    logic [ACC_W-1:0] run_full;
    logic             run_fits;

    // Rice:  acc holds (Z<<kr)|r directly.
    // EG:    acc holds m = (1<<(z+ke))|b; the marker bit was preloaded at the '1'.
    function automatic logic [ACC_W-1:0] final_run(input logic [ACC_W-1:0] acc,
                                                   input logic             rice,
                                                   input run_codebook_t    cb);
        if (rice) begin
            return acc;
        end
        return acc - (ACC_W'(1) << cb.ke) + (ACC_W'(cb.lastq_plus1) << cb.kr);
    endfunction

    assign bus.in_ready  = ((state_q == ST_PREFIX) || (state_q == ST_SUFFIX))
                           && !bus.block_start && !reset;
    assign bus.out_valid = (state_q == ST_EMIT);
    assign bus.out_error = (state_q == ST_ERROR);
    assign bus.out_run   = run_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign zcnt_inc   = accept && (state_q == ST_PREFIX) && !bus.in_bit;
    assign zcnt_clear = bus.block_start || ((state_q == ST_EMIT) && bus.out_ready);

    vlc_bit_prefix_counter #(
        .MAX_COUNT (MAX_PREFIX),
        .CNT_W     (ZCNT_W)
    ) u_prefix (
        .clk     (clk),
        .reset   (reset),
        .clear_i (zcnt_clear),
        .inc_i   (zcnt_inc),
        .count_o (zcnt),
        .limit_o (zcnt_limit)
    );

    // Codebook and suffix setup as seen when the terminating '1' arrives.
    always_comb begin
        cb_new   = run_codebook(prev_q);
        rice_new = (zcnt < ZCNT_W'(cb_new.lastq_plus1));
        if (rice_new) begin
            acc_init = ACC_W'(zcnt);
            len_new  = LEN_W'(cb_new.kr);
        end else begin
            acc_init = ACC_W'(1);
            len_new  = LEN_W'(zcnt) - LEN_W'(cb_new.lastq_plus1) + LEN_W'(cb_new.ke);
        end
        acc_shift = (acc_q << 1) | ACC_W'(bus.in_bit);

        // Completion can happen from PREFIX (empty suffix) or on the last SUFFIX bit.
        if (state_q == ST_PREFIX) begin
            fin_acc  = acc_init;
            fin_rice = rice_new;
            fin_cb   = cb_new;
        end else begin
            fin_acc  = acc_shift;
            fin_rice = rice_q;
            fin_cb   = cb_q;
        end
        run_full = final_run(fin_acc, fin_rice, fin_cb);
        // Range check on the full-width result, before truncation to RUN_W.
        run_fits = (run_full >> RUN_W) == '0;
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        acc_d   = acc_q;
        len_d   = len_q;
        cb_d    = cb_q;
        rice_d  = rice_q;
        run_d   = run_q;

        if (bus.block_start) begin
            state_d = ST_PREFIX;
            prev_d  = RUN_CTX_INIT;
            acc_d   = '0;
            len_d   = '0;
        end else begin
            unique case (state_q)
                ST_PREFIX: begin
                    if (accept) begin
                        if (!bus.in_bit) begin
                            if (zcnt_limit) begin
                                state_d = ST_ERROR;
                            end
                        end else begin
                            cb_d   = cb_new;
                            rice_d = rice_new;
                            acc_d  = acc_init;
                            len_d  = len_new;
                            if (len_new == '0) begin
                                if (run_fits) begin
                                    run_d   = run_full[RUN_W-1:0];
                                    state_d = ST_EMIT;
                                end else begin
                                    state_d = ST_ERROR;
                                end
                            end else begin
                                state_d = ST_SUFFIX;
                            end
                        end
                    end
                end
                ST_SUFFIX: begin
                    if (accept) begin
                        acc_d = acc_shift;
                        len_d = len_q - 1'b1;
                        if (len_q == LEN_W'(1)) begin
                            if (run_fits) begin
                                run_d   = run_full[RUN_W-1:0];
                                state_d = ST_EMIT;
                            end else begin
                                state_d = ST_ERROR;
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        prev_d  = (run_q > RUN_W'(RUN_CTX_MAX)) ? RUN_CTX_MAX : run_q[3:0];
                        acc_d   = '0;
                        len_d   = '0;
                        state_d = ST_PREFIX;
                    end
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_PREFIX;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_PREFIX;
            prev_q  <= RUN_CTX_INIT;
            acc_q   <= '0;
            len_q   <= '0;
            cb_q    <= '0;
            rice_q  <= 1'b0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            cb_q    <= cb_d;
            rice_q  <= rice_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: tb/tb_entropy_decode_ac_run_coefficients_bits.sv
// tb/tb_entropy_decode_ac_run_coefficients_bits.sv - scoreboard bench for the AC run decoder
module tb_entropy_decode_ac_run_coefficients_bits;

    localparam int RUN_W      = 16;
    localparam int MAX_PREFIX = 24;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    entropy_decode_ac_run_coefficients_bits_if #(.RUN_W(RUN_W)) bus ();

    entropy_decode_ac_run_coefficients_bits #(
        .RUN_W      (RUN_W),
        .MAX_PREFIX (MAX_PREFIX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [RUN_W-1:0] exp_q[$];
    logic [RUN_W-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every run the decoder hands over is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_run: got %0d expected no output", bus.out_run);
            end else begin
                mon_exp = exp_q.pop_front();
                check("run", 32'(bus.out_run), 32'(mon_exp));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the bit was taken.
    task automatic send_bit(input logic b);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: got in_ready=%b expected 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rep(input logic b, input int n);
        for (int i = 0; i < n; i++) send_bit(b);
    endtask

    task automatic send_code(input string s, input int unsigned exp_run, input bit expect_out);
        if (expect_out) exp_q.push_back(RUN_W'(exp_run));
        for (int i = 0; i < s.len(); i++) send_bit(s[i] == "1");
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_block_start();
        bus.block_start = 1'b1;
        bus.in_valid    = 1'b0;
        @(negedge clk);
        check("in_ready_during_block_start", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.block_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.block_start = 1'b0;
        bus.in_bit      = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_error", 32'(bus.out_error), 32'd0);
        check("reset_out_run",   32'(bus.out_run),   32'd0);
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;

        // Context chain from reset: 4 -> 0 -> 2 -> 0 -> 3.
        send_code("1",     0, 1);
        send_code("001",   2, 1);
        send_code("1",     0, 1);
        send_code("00010", 3, 1);
        wait_drain();

        // prev 4 EG k0, then prev 6 Rice k1.
        pulse_block_start();
        send_code("00111", 6, 1);
        send_code("011",   3, 1);
        wait_drain();

        // Saturation of the context to 15, then EG k2.
        pulse_block_start();
        send_code("000010101", 20, 1);
        send_code("100",        0, 1);
        wait_drain();

        // Largest run that fits RUN_W: 16 zeros, 1, 16 zeros -> 65535.
        pulse_block_start();
        exp_q.push_back(RUN_W'(65535));
        send_rep(1'b0, 16);
        send_bit(1'b1);
        send_rep(1'b0, 16);
        wait_drain();

        // One above the range: 16 zeros, 1, 15 zeros, 1 -> 65536 does not fit.
        pulse_block_start();
        send_rep(1'b0, 16);
        send_bit(1'b1);
        send_rep(1'b0, 15);
        send_bit(1'b1);
        @(negedge clk);
        check("ovf_out_error", 32'(bus.out_error), 32'd1);
        check("ovf_out_valid", 32'(bus.out_valid), 32'd0);
        check("ovf_in_ready",  32'(bus.in_ready),  32'd0);
        @(posedge clk);
        #1;

        // Backpressure: run held stable while out_ready is low.
        pulse_block_start();
        check("error_cleared_by_block_start", 32'(bus.out_error), 32'd0);
        bus.out_ready = 1'b0;
        send_code("00111", 6, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_out_run",   32'(bus.out_run),   32'd6);
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_drain();

        // block_start inside the suffix of "011" (prev 6): partial dropped.
        send_bit(1'b0);
        send_bit(1'b1);
        pulse_block_start();
        send_code("1", 0, 1);
        wait_drain();

        // 25 zeros exceed MAX_PREFIX: sticky error until block_start.
        pulse_block_start();
        send_rep(1'b0, MAX_PREFIX + 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("prefix_err_out_error", 32'(bus.out_error), 32'd1);
            check("prefix_err_in_ready",  32'(bus.in_ready),  32'd0);
            check("prefix_err_out_valid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        pulse_block_start();
        @(negedge clk);
        check("recover_out_error", 32'(bus.out_error), 32'd0);
        check("recover_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;
        send_code("1", 0, 1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
